dispatch_int_stage: RTL
=======================

Name: dispatch_int_stage

Overview:
- Dispatch-side transmitter feeding the integer execution queue over the dispatch_* interface (opcode, rd/rs/rt tags, operand data, operand-valid flags, dispatch_en / dispatch_ready).
- Buffers decoded integer instructions from decode in a small FIFO.
- Snoops the CDB so that waiting operands wake up while dispatch is stalled.
- Discards buffered work on a taken-branch CDB broadcast.

Parameters:
- DEPTH, 2, number of buffered instructions; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- dec_valid  input  1  decode presents an instruction
- dec_ready  output  1  stage can accept this cycle
- dec_opcode  input  3  integer opcode
- dec_rdtag  input  6  destination tag
- dec_rstag  input  6  rs source tag
- dec_rttag  input  6  rt source tag
- dec_rsdata  input  32  rs data (meaningful when dec_rsvalid)
- dec_rtdata  input  32  rt data (meaningful when dec_rtvalid)
- dec_rsvalid  input  1  rs data present
- dec_rtvalid  input  1  rt data present
- cdb_tag  input  6  broadcast result tag
- cdb_data  input  32  broadcast result data
- cdb_valid  input  1  broadcast valid
- cdb_branch  input  1  broadcast is a resolved branch
- cdb_branch_taken  input  1  resolved branch taken (flush)
- dispatch_opcode  output  3  head opcode
- dispatch_rdtag  output  6  head rd tag
- dispatch_rstag  output  6  head rs tag
- dispatch_rttag  output  6  head rt tag
- dispatch_rsdata  output  32  head rs data
- dispatch_rtdata  output  32  head rt data
- dispatch_rsvalid  output  1  head rs valid
- dispatch_rtvalid  output  1  head rt valid
- dispatch_en  output  1  head instruction offered
- dispatch_ready  input  1  integer queue accepts

Behaviour:
- Reset (async, immediate):
  - All entries invalid; read/write pointers 0; count 0.
  - dispatch_en = 0; all dispatch_* fields = 0; dec_ready = 1.
- Signal definitions:
  - flush = cdb_valid & cdb_branch & cdb_branch_taken.
  - push = dec_valid & dec_ready.
  - pop = dispatch_en & dispatch_ready.
- dec_ready = (count != DEPTH). It does not depend on dispatch_ready: a full buffer plus a pop in the same cycle still refuses the push.
- dispatch_en = (count != 0) & ~flush. The dispatch_* fields reflect the head entry, and are 0 when empty.
- Latency: an instruction pushed at edge N is offered from cycle N+1. Minimum decode-to-dispatch latency is 1 cycle; no combinational pass-through.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Flush: at the edge, all entries are invalidated and count = 0. A push in the flush cycle is dropped. A flush has priority over push, pop and snoop.
- CDB snoop, every edge with cdb_valid & ~flush:
  - Each stored entry with rsvalid = 0 and rstag == cdb_tag latches rsdata = cdb_data and rsvalid = 1. Same rule independently for rt.
  - An entry being pushed that cycle is also checked against the CDB before it is written, so a same-cycle wakeup is never lost.
  - Operands already valid are never overwritten.
- Ordering: strict FIFO; no reordering.
- Full and empty are both legal steady states. Pop while empty and push while full cannot occur (gated).

Optional Feature:
- CDB_BYPASS_EN defined: the head operands are combinationally forwarded. If the head has rsvalid = 0, rstag == cdb_tag and cdb_valid = 1 in the current cycle, then dispatch_rsdata = cdb_data and dispatch_rsvalid = 1 in that same cycle. Same rule for rt.
- CDB_BYPASS_EN undefined: outputs show stored state only. The integer queue must itself snoop the CDB in the dispatch cycle.
- Stored-entry snooping is identical in both builds.

Test Plan:
- Reset mid-operation: assert reset with 2 entries held -> dispatch_en = 0, dec_ready = 1 and all dispatch_* = 0 immediately, without waiting for a clock edge.
- Basic flow: push opcode=3'b010, rdtag=6'd5, rsdata=32'h11, rsvalid=1 at edge N with dispatch_ready=1 -> dispatch_en=1 in cycle N+1 with those fields; empty again at N+2.
- Back-pressure: dispatch_ready=0 while pushing 3 instructions (DEPTH=2) -> dec_ready=0 after the 2nd push. Then raise dispatch_ready -> instructions emerge in order A, B, C, one per cycle.
- Wakeup: stalled entry with rstag=6'd9, rsvalid=0; CDB tag=9, data=32'hDEADBEEF -> next cycle dispatch_rsvalid=1 and dispatch_rsdata=32'hDEADBEEF. A CDB with tag=9 that arrives in the same cycle the entry is pushed -> the entry is stored already valid.
- Flush: 2 entries held, plus push and cdb_branch & cdb_branch_taken & cdb_valid in the same cycle -> dispatch_en=0 that cycle, count=0 next cycle, and the pushed instruction never appears.
- Bypass (CDB_BYPASS_EN): head rttag=6'd12, rtvalid=0, CDB tag=12, data=32'h7 -> dispatch_rtvalid=1 and dispatch_rtdata=32'h7 in the same cycle. Without the macro -> rtvalid=0 that cycle and 1 the next.

Source files
------------

// File: rtl/dispatch_int_stage.sv
// dispatch_int_stage: FIFO between decode and the integer execution queue.
// Buffers decoded integer instructions, wakes waiting operands from CDB
// broadcasts while they sit in the buffer, and discards everything on a
// taken-branch broadcast.
// Optional build macro CDB_BYPASS_EN: when defined, the head operands are
// forwarded combinationally from a matching CDB broadcast in the same cycle.
module dispatch_int_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [2:0]  dec_opcode,
  input  logic [5:0]  dec_rdtag,
  input  logic [5:0]  dec_rstag,
  input  logic [5:0]  dec_rttag,
  input  logic [31:0] dec_rsdata,
  input  logic [31:0] dec_rtdata,
  input  logic        dec_rsvalid,
  input  logic        dec_rtvalid,
  input  logic [5:0]  cdb_tag,
  input  logic [31:0] cdb_data,
  input  logic        cdb_valid,
  input  logic        cdb_branch,
  input  logic        cdb_branch_taken,
  output logic [2:0]  dispatch_opcode,
  output logic [5:0]  dispatch_rdtag,
  output logic [5:0]  dispatch_rstag,
  output logic [5:0]  dispatch_rttag,
  output logic [31:0] dispatch_rsdata,
  output logic [31:0] dispatch_rtdata,
  output logic        dispatch_rsvalid,
  output logic        dispatch_rtvalid,
  output logic        dispatch_en,
  input  logic        dispatch_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Entry storage
  logic [2:0]  r_opcode  [DEPTH];
  logic [5:0]  r_rdtag   [DEPTH];
  logic [5:0]  r_rstag   [DEPTH];
  logic [5:0]  r_rttag   [DEPTH];
  logic [31:0] r_rsdata  [DEPTH];
  logic [31:0] r_rtdata  [DEPTH];
  logic        r_rsvalid [DEPTH];
  logic        r_rtvalid [DEPTH];
  logic        r_valid   [DEPTH];

  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_count;

  logic        w_flush;
  logic        w_push;
  logic        w_pop;
  logic        w_nonempty;
  logic        w_push_rs_hit;
  logic        w_push_rt_hit;
  logic [31:0] w_push_rsdata;
  logic [31:0] w_push_rtdata;

  assign w_flush    = cdb_valid & cdb_branch & cdb_branch_taken;
  assign w_nonempty = (r_count != '0);
  assign dec_ready  = (r_count != FULL_CNT);
  assign dispatch_en = w_nonempty & ~w_flush;
  assign w_push     = dec_valid & dec_ready;
  assign w_pop      = dispatch_en & dispatch_ready;

  // Incoming instruction is checked against the CDB so a same-cycle wakeup is kept
  assign w_push_rs_hit = cdb_valid & ~dec_rsvalid & (dec_rstag == cdb_tag);
  assign w_push_rt_hit = cdb_valid & ~dec_rtvalid & (dec_rttag == cdb_tag);
  assign w_push_rsdata = w_push_rs_hit ? cdb_data : dec_rsdata;
  assign w_push_rtdata = w_push_rt_hit ? cdb_data : dec_rtdata;

  // FIFO state: flush, stored-entry snoop, push write, pop, pointer/count update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_opcode[i]  <= 3'd0;
        r_rdtag[i]   <= 6'd0;
        r_rstag[i]   <= 6'd0;
        r_rttag[i]   <= 6'd0;
        r_rsdata[i]  <= 32'd0;
        r_rtdata[i]  <= 32'd0;
        r_rsvalid[i] <= 1'b0;
        r_rtvalid[i] <= 1'b0;
        r_valid[i]   <= 1'b0;
      end
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
      end
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (cdb_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_valid[i] && !r_rsvalid[i] && (r_rstag[i] == cdb_tag)) begin
            r_rsdata[i]  <= cdb_data;
            r_rsvalid[i] <= 1'b1;
          end
          if (r_valid[i] && !r_rtvalid[i] && (r_rttag[i] == cdb_tag)) begin
            r_rtdata[i]  <= cdb_data;
            r_rtvalid[i] <= 1'b1;
          end
        end
      end
      if (w_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + PW'(1);
      end
      if (w_push) begin
        r_opcode[r_wptr]  <= dec_opcode;
        r_rdtag[r_wptr]   <= dec_rdtag;
        r_rstag[r_wptr]   <= dec_rstag;
        r_rttag[r_wptr]   <= dec_rttag;
        r_rsdata[r_wptr]  <= w_push_rsdata;
        r_rtdata[r_wptr]  <= w_push_rtdata;
        r_rsvalid[r_wptr] <= dec_rsvalid | w_push_rs_hit;
        r_rtvalid[r_wptr] <= dec_rtvalid | w_push_rt_hit;
        r_valid[r_wptr]   <= 1'b1;
        r_wptr            <= r_wptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry presentation; all fields read as zero when the buffer is empty
  always_comb begin
    dispatch_opcode  = 3'd0;
    dispatch_rdtag   = 6'd0;
    dispatch_rstag   = 6'd0;
    dispatch_rttag   = 6'd0;
    dispatch_rsdata  = 32'd0;
    dispatch_rtdata  = 32'd0;
    dispatch_rsvalid = 1'b0;
    dispatch_rtvalid = 1'b0;
    if (w_nonempty) begin
      dispatch_opcode  = r_opcode[r_rptr];
      dispatch_rdtag   = r_rdtag[r_rptr];
      dispatch_rstag   = r_rstag[r_rptr];
      dispatch_rttag   = r_rttag[r_rptr];
      dispatch_rsdata  = r_rsdata[r_rptr];
      dispatch_rtdata  = r_rtdata[r_rptr];
      dispatch_rsvalid = r_rsvalid[r_rptr];
      dispatch_rtvalid = r_rtvalid[r_rptr];
`ifdef CDB_BYPASS_EN
      // Forward a matching broadcast straight onto a waiting head operand
      if (cdb_valid && !r_rsvalid[r_rptr] && (r_rstag[r_rptr] == cdb_tag)) begin
        dispatch_rsdata  = cdb_data;
        dispatch_rsvalid = 1'b1;
      end else begin
        dispatch_rsdata  = r_rsdata[r_rptr];
      end
      if (cdb_valid && !r_rtvalid[r_rptr] && (r_rttag[r_rptr] == cdb_tag)) begin
        dispatch_rtdata  = cdb_data;
        dispatch_rtvalid = 1'b1;
      end else begin
        dispatch_rtdata  = r_rtdata[r_rptr];
      end
`endif
    end else begin
      dispatch_en_unused_hold();
    end
  end

  function automatic void dispatch_en_unused_hold();
  endfunction

endmodule
